// File: rtl/seg7_pkg.sv
// seg7_pkg: segment table and code constants shared by both ends of the display path
package seg7_pkg;

    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

    // Active-low a..g patterns for each decimal digit
    localparam logic [6:0] PAT_0 = 7'b0000001;
    localparam logic [6:0] PAT_1 = 7'b1001111;
    localparam logic [6:0] PAT_2 = 7'b0010010;
    localparam logic [6:0] PAT_3 = 7'b0000110;
    localparam logic [6:0] PAT_4 = 7'b1001100;
    localparam logic [6:0] PAT_5 = 7'b0100100;
    localparam logic [6:0] PAT_6 = 7'b0100000;
    localparam logic [6:0] PAT_7 = 7'b0001111;
    localparam logic [6:0] PAT_8 = 7'b0000000;
    localparam logic [6:0] PAT_9 = 7'b0000100;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_ILLEGAL = 4'hE;

    localparam logic [9:0][6:0] DIGIT_PAT = {
        PAT_9, PAT_8, PAT_7, PAT_6, PAT_5, PAT_4, PAT_3, PAT_2, PAT_1, PAT_0
    };

endpackage

// File: rtl/seg7_pattern_to_bcd.sv
// seg7_pattern_to_bcd: inverse of the digit table, a..g pattern to BCD plus illegal flag
module seg7_pattern_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       err
);

    // Look the pattern up in the shared table; unmatched patterns are blank or illegal
    always_comb begin
        bcd = pattern == SEG_BLANK ? BCD_BLANK : BCD_ILLEGAL;
        err = pattern != SEG_BLANK;
        for (int i = 0; i < 10; i++)
            if (pattern == DIGIT_PAT[i]) begin
                bcd = 4'(i);
                err = 1'b0;
            end
    end

endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: reconstructs the digits shown on a multiplexed 7-segment display
module seg7_scan_capture
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [7:0]              seg,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    frame_valid,
    output logic                    timeout
);

    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SW-1:0] STABLE_MAX   = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [NUM_DIGITS-1:0]   an_s1, an_s2, an_prev;
    logic [7:0]              seg_s1, seg_s2, seg_prev;
    logic [SW-1:0]           cnt, cnt_next;
    logic [TW-1:0]           tcnt;
    logic [NUM_DIGITS-1:0]   seen;
    logic [4*NUM_DIGITS-1:0] sh_bcd;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_err;
    logic [3:0]              lows;
    logic [IW-1:0]           idx;
    logic                    valid, same, capture, frame_done, expire;
    logic [3:0]              dec_bcd;
    logic                    dec_err;

    seg7_pattern_to_bcd u_dec (
        .pattern (seg_s2[SEG_A:SEG_G]),
        .bcd     (dec_bcd),
        .err     (dec_err)
    );

    // Active digit index and validity: exactly one anode low, else treat as blanking
    always_comb begin
        lows = '0;
        idx  = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!an_s2[i]) begin
                lows = lows + 4'd1;
                idx  = IW'(i);
            end
        valid      = lows == 4'd1;
        same       = {an_s2, seg_s2} == {an_prev, seg_prev};
        cnt_next   = !valid ? '0 : !same ? SW'(1) : cnt == STABLE_MAX ? cnt : cnt + SW'(1);
        capture    = valid && cnt_next == STABLE_MAX && !(same && cnt == STABLE_MAX) && !seen[idx];
        frame_done = &seen;
        expire     = !capture && tcnt == TIMEOUT_LAST;
    end

    // Two-flop synchronizers, idle (all ones) out of reset
    always_ff @(posedge clk) begin
        if (reset) begin
            an_s1  <= '1;
            an_s2  <= '1;
            seg_s1 <= '1;
            seg_s2 <= '1;
        end else begin
            an_s1  <= an;
            an_s2  <= an_s1;
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
        end
    end

    // Remember last sample and count how long it has stayed unchanged
    always_ff @(posedge clk) begin
        if (reset) begin
            an_prev  <= '1;
            seg_prev <= '1;
            cnt      <= '0;
        end else begin
            an_prev  <= an_s2;
            seg_prev <= seg_s2;
            cnt      <= cnt_next;
        end
    end

    // Latch the first stable value of each digit into the shadow set for this frame
    always_ff @(posedge clk) begin
        if (reset) begin
            seen   <= '0;
            sh_bcd <= '1;
            sh_dp  <= '0;
            sh_err <= '0;
        end else if (frame_done || expire) begin
            seen <= '0;
        end else if (capture) begin
            seen[idx]          <= 1'b1;
            sh_bcd[4*idx +: 4] <= dec_bcd;
            sh_dp[idx]         <= ~seg_s2[SEG_DP];
            sh_err[idx]        <= dec_err;
        end
    end

    // Idle timer: abandon a partial frame when no digit has been captured for too long
    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= capture || expire ? '0 : tcnt + TW'(1);
            timeout <= expire;
        end
    end

    // Publish the shadow set once every digit has been seen
    always_ff @(posedge clk) begin
        if (reset) begin
            bcd_out     <= '1;
            dp_out      <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            frame_valid <= frame_done;
            if (frame_done) begin
                bcd_out   <= sh_bcd;
                dp_out    <= sh_dp;
                digit_err <= sh_err;
            end
        end
    end

endmodule
